encoder_serial_scan: RTL and testbench

ENCODER_SERIAL_SCAN -- requirements
Module: encoder_serial_scan

---
 rtl/encoder_pkg.sv | 11 +
 rtl/priority_pick.sv | 36 +++
 rtl/encoder_serial_scan.sv | 112 +++++++++++
 tb/tb_encoder_serial_scan.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types and defaults for the serial scan encoder
package encoder_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/priority_pick.sv
// rtl/priority_pick.sv - picks one set bit: index, one-hot mask, single-bit flag
// Scan order follows ENCODER_SERIAL_SCAN_MSB_FIRST_EN (defined: highest bit, else lowest).
module priority_pick
  import encoder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic [WIDTH-1:0] o_onehot,
  output logic             o_single
);

  logic w_any;

  assign w_any = (i_vec != '0);

  // The last match written wins, so loop direction sets the priority.
  always_comb begin
    o_idx = '0;
`ifdef ENCODER_SERIAL_SCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
`endif
  end

  assign o_onehot = w_any ? (WIDTH'(1) << o_idx) : '0;
  assign o_single = w_any && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/encoder_serial_scan.sv
// rtl/encoder_serial_scan.sv - emits the index of every set bit of a vector, one beat per handshake
// Scan order selected by ENCODER_SERIAL_SCAN_MSB_FIRST_EN (see priority_pick).
module encoder_serial_scan
  import encoder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] vector_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] binary_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_pending;
  logic [IDX_W-1:0] r_binary;
  logic             r_valid;
  logic             r_last;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [IDX_W-1:0] w_binary_nxt;
  logic             w_valid_nxt;
  logic             w_last_nxt;

  logic [WIDTH-1:0] w_pick_in;
  logic [IDX_W-1:0] w_pick_idx;
  logic [WIDTH-1:0] w_pick_onehot;
  logic             w_pick_single;
  logic             w_capture;
  logic             w_handshake;

  // r_pending holds only the bits not yet presented, so one picker serves
  // both the capture path and the advance path.
  assign w_pick_in   = (r_state == IDLE) ? vector_in : r_pending;
  assign w_capture   = in_valid && in_ready;
  assign w_handshake = r_valid && out_ready;

  priority_pick #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_vec    (w_pick_in),
    .o_idx    (w_pick_idx),
    .o_onehot (w_pick_onehot),
    .o_single (w_pick_single)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_binary_nxt  = r_binary;
    w_valid_nxt   = r_valid;
    w_last_nxt    = r_last;
    case (r_state)
      IDLE: begin
        if (w_capture && (vector_in != '0)) begin
          w_state_nxt   = SCAN;
          w_pending_nxt = vector_in & ~w_pick_onehot;
          w_binary_nxt  = w_pick_idx;
          w_valid_nxt   = 1'b1;
          w_last_nxt    = w_pick_single;
        end
      end
      SCAN: begin
        if (w_handshake) begin
          if (r_pending == '0) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
          end else begin
            w_pending_nxt = r_pending & ~w_pick_onehot;
            w_binary_nxt  = w_pick_idx;
            w_last_nxt    = w_pick_single;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_binary  <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_binary  <= w_binary_nxt;
      r_valid   <= w_valid_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign in_ready   = (r_state == IDLE) && enable;
  assign busy       = (r_state == SCAN);
  assign binary_out = r_binary;
  assign out_valid  = r_valid;
  assign out_last   = r_last;

endmodule

// File: tb/tb_encoder_serial_scan.sv
// tb/tb_encoder_serial_scan.sv - self-checking bench for encoder_serial_scan
module tb_encoder_serial_scan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] vector_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  binary_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;

  encoder_serial_scan #(.WIDTH(16), .IDX_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .vector_in  (vector_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .binary_out (binary_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
  } beat_t;

  typedef struct {
    logic [15:0] vec;
    int          beats;
    int          first_lsb;
    int          first_msb;
  } vec_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    beat_cnt = 0;
  int    first_v = -1;
  int    first_bin = -1;
  int    last_hs = -1;
  int    rdy_mode = 0;
  int    ph = 0;

  logic       prev_stall = 1'b0;
  logic       prev_rst_n = 1'b0;
  logic [3:0] prev_bin = '0;
  logic       prev_last = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_model(input logic [15:0] v);
    int n;
    int k;
    beat_t e;
    n = 0;
    k = 0;
    for (int j = 0; j < 16; j++) if (v[j]) n++;
    for (int j = 0; j < 16; j++) begin
      int i;
`ifdef ENCODER_SERIAL_SCAN_MSB_FIRST_EN
      i = 15 - j;
`else
      i = j;
`endif
      if (v[i]) begin
        k++;
        e.idx  = i;
        e.last = (k == n);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) begin
      out_ready = 1'b1;
    end else if (out_valid) begin
      out_ready = (ph % 2 == 0);
      ph++;
    end else begin
      out_ready = 1'b1;
      ph = 0;
    end
  end

  // Scoreboard and stall-stability monitor.
  always @(negedge clk) begin
    if (prev_stall && prev_rst_n && reset_n) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_bin", binary_out, prev_bin);
      chk("stall_last", out_last, prev_last);
    end
    if (out_valid === 1'b1 && first_v < 0) first_v = cyc;
    if (out_valid === 1'b1 && out_ready) begin
      beat_cnt++;
      if (first_bin < 0) first_bin = int'(binary_out);
      if (out_last) last_hs = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got index %0d expected none (cycle %0d)", binary_out, cyc);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_index", int'(binary_out), e.idx);
        chk("beat_last", out_last, e.last);
      end
    end
    prev_stall = (out_valid === 1'b1) && !out_ready;
    prev_rst_n = reset_n;
    prev_bin   = binary_out;
    prev_last  = out_last;
  end

  task automatic clear_stats();
    beat_cnt  = 0;
    first_v   = -1;
    first_bin = -1;
    last_hs   = -1;
  endtask

  task automatic send(input logic [15:0] v);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    in_valid  = 1'b1;
    vector_in = v;
    push_model(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((busy || out_valid) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy || out_valid) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0d expected 0", busy);
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{16'h8421, 4, 0, 15};
    tbl[1] = '{16'h0001, 1, 0, 0};
    tbl[2] = '{16'h8000, 1, 15, 15};
    tbl[3] = '{16'h00F0, 4, 4, 7};
    tbl[4] = '{16'h1234, 5, 2, 12};
    tbl[5] = '{16'h0003, 2, 0, 1};
    tbl[6] = '{16'hAAAA, 8, 1, 15};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bin", binary_out, 0);
    chk("rst_last", out_last, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    send(16'h0000);
    for (int i = 0; i < 3; i++) begin
      chk("zero_valid", out_valid, 0);
      chk("zero_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 7; i++) begin
      clear_stats();
      send(tbl[i].vec);
      wait_idle(100);
      chk("tbl_beats", beat_cnt, tbl[i].beats);
      chk("tbl_span", last_hs - first_v, tbl[i].beats - 1);
`ifdef ENCODER_SERIAL_SCAN_MSB_FIRST_EN
      chk("tbl_first", first_bin, tbl[i].first_msb);
`else
      chk("tbl_first", first_bin, tbl[i].first_lsb);
`endif
    end

    clear_stats();
    rdy_mode = 1;
    send(16'hFFFF);
    wait_idle(200);
    chk("ffff_beats", beat_cnt, 16);
    chk("ffff_cycles", last_hs - first_v + 1, 31);
    rdy_mode = 0;
    @(posedge clk); #1;

    clear_stats();
    in_valid  = 1'b1;
    vector_in = 16'h0003;
    push_model(16'h0003);
    @(posedge clk); #1;
    vector_in = 16'h0100;
    for (int t = 0; t < 50; t++) begin
      if (busy) begin
        chk("scan_in_ready", in_ready, 0);
      end else begin
        chk("reopen_cycle", cyc, last_hs + 1);
        chk("reopen_in_ready", in_ready, 1);
        push_model(16'h0100);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle(100);
    chk("held_beats", beat_cnt, 3);

    clear_stats();
    send(16'h00F0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bin", binary_out, 0);
    chk("abort_left", exp_q.size(), 2);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_beats", beat_cnt, 2);

    clear_stats();
    enable    = 1'b0;
    in_valid  = 1'b1;
    vector_in = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("dis_in_ready", in_ready, 0);
      chk("dis_valid", out_valid, 0);
      chk("dis_busy", busy, 0);
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    @(posedge clk); #1;
    send(16'h0003);
    enable = 1'b0;
    wait_idle(100);
    chk("dis_mid_beats", beat_cnt, 2);
    enable = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
